// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types, default baud divisor and counter sizing
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 87;

    // Width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with selectable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RESET_VAL;
            q  <= RESET_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART 8N1 receiver with holding register; UART_RX_PARITY_EN adds a parity bit
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int            CW        = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          rxs;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          par_bad_q;
    logic          commit_stb_q;

    logic cnt_clr, sample_bit, par_sample, set_frame, set_par, commit;
    logic par_expect, overrun_set;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    assign par_expect = (^shift_q) ^ PARITY_ODD;

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        sample_bit = 1'b0;
        par_sample = 1'b0;
        set_frame  = 1'b0;
        set_par    = 1'b0;
        commit     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) state_d = rxs ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    sample_bit = 1'b1;
                    cnt_clr    = 1'b1;
                    if (bit_idx_q == 3'd7) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    par_sample = 1'b1;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at mid-stop-bit so the next start edge is not missed.
                if (cnt_q == BIT_LAST) begin
                    if (!rxs) begin
                        set_frame = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end else if (PARITY_EN && par_bad_q) begin
                        set_par = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            commit_stb_q <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= (cnt_clr || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
            commit_stb_q <= commit;
            busy         <= (state_d != ST_IDLE);
            if (state_d == ST_DATA && state_q != ST_DATA) begin
                bit_idx_q <= '0;
            end else if (sample_bit) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (sample_bit) shift_q <= {rxs, shift_q[7:1]};
            if (state_q == ST_IDLE) begin
                par_bad_q <= 1'b0;
            end else if (par_sample) begin
                par_bad_q <= (rxs != par_expect);
            end
        end
    end

    assign overrun_set = commit_stb_q && rx_valid && !rx_ready;

    // Set events take priority over a same-cycle err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (commit_stb_q && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (!commit_stb_q && rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            frame_err  <= set_frame | (frame_err & ~err_clr);
            overrun    <= overrun_set | (overrun & ~err_clr);
            parity_err <= set_par | (parity_err & ~err_clr);
        end
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive stage of the `tt_um_captmodterm13_uart` design. It sits directly upstream of the byte consumer: it samples the asynchronous `rxd` pin, recovers 8N1 frames at a fixed baud divisor, and presents each received byte through a valid/ready holding register. Framing and overrun conditions are reported as sticky flags until software or the wrapper clears them.

## Interface
- `CLKS_PER_BIT`, default 87: clk cycles per bit (10 MHz / 115200). Must be ≥ 4.
- `PARITY_ODD`, default 0: 1 selects odd parity and 0 selects even. Only meaningful with `UART_RX_PARITY_EN`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rxd` in 1: asynchronous serial input, idle high.
- `rx_data` out 8: received byte, valid while `rx_valid`=1.
- `rx_valid` out 1: holding register full.
- `rx_ready` in 1: consumer accepts; transfer when `rx_valid && rx_ready`.
- `err_clr` in 1: clears all sticky error flags.
- `frame_err` out 1: sticky; stop bit sampled low.
- `overrun` out 1: sticky; byte completed while holding register was full.
- `parity_err` out 1: sticky; parity mismatch.
- `busy` out 1: FSM not in IDLE.

## Operation
- `rxd` passes through 2 flip-flop synchronizer stages, both reset to 1. The FSM sees only the synchronized signal `rxs`.
- HALF = CLKS_PER_BIT/2 (floor). The bit counter is wide enough for CLKS_PER_BIT-1 and is cleared on every state entry.
- IDLE: when `rxs`=0, go to START.
- START: after HALF cycles, sample `rxs`.
  - If 1, treat it as a glitch and return to IDLE.
  - If 0, go to DATA with bit index 0.
- DATA: every CLKS_PER_BIT cycles, shift `rxs` in LSB-first. After the 8th bit, go to PARITY if it is compiled in, else STOP.
- PARITY: after CLKS_PER_BIT cycles, sample and compare.
- STOP: after CLKS_PER_BIT cycles, sample `rxs`.
  - Sample 1 with no parity error: commit the byte and return to IDLE immediately, at mid-stop-bit, so the next start edge can be caught.
  - Sample 0: set `frame_err`, discard the byte, go to WAIT_IDLE.
  - Parity error: set `parity_err`, discard the byte, go to IDLE.
- WAIT_IDLE: stay until `rxs`=1, then go to IDLE. This state handles break conditions.
- Commit rules:
  - Holding register empty, or `rx_ready`=1 in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise set `overrun`=1, drop the new byte, and leave `rx_data` unchanged.
- `rx_valid` clears on a transfer with no simultaneous commit. Commit and pop in the same cycle leaves `rx_valid`=1 with the new data and no overrun.
- `err_clr` clears the flags. A flag set event in the same cycle as `err_clr` wins.
- Reset mid-frame abandons the frame. State returns to IDLE and the partial byte is lost.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `parity_err`=0, `busy`=0, synchronizer=1, state=IDLE.
- Latency: `rx_valid` rises HALF + 9·CLKS_PER_BIT + 4 clk edges after the first edge sampling `rxd` low. The 4 cycles are 2 synchronizer stages, 1 IDLE detect, and 1 output register. With parity, add CLKS_PER_BIT.
- `rx_data` is stable for every cycle `rx_valid`=1 and changes only on commit.
- `busy` is registered and goes high the cycle after IDLE exits START detection.
- Maximum throughput is one byte per frame time with `rx_ready` held high. There are no bubbles between frames.

## Configuration
- `UART_RX_PARITY_EN` defined: adds the PARITY state and a 9th bit before stop. Expected parity is XOR of the data bits, inverted if `PARITY_ODD`=1. `parity_err` is live.
- Not defined: frame is 8N1, there is no PARITY state, and `parity_err` is tied to 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - the default CLKS_PER_BIT constant;
  - the counter-width function ($clog2-based).
- Sub-module `uart_sync2`: parameterised-reset-value 2-FF synchronizer, reused later by the TX CTS input.

## Test plan
- CLKS_PER_BIT=8, send 0xA5 with `rx_ready`=1 → `rx_valid` pulses 1 cycle, exactly 4+72+4=80 edges after the start edge, with `rx_data`=0xA5 and all flags 0.
- Hold `rxd` low for 2 cycles only → no `rx_valid`, `busy` returns to 0 within HALF+3 cycles, state IDLE.
- Send 0x3C with the stop bit low, then hold the line low for 20 cycles → `frame_err`=1, no `rx_valid`, next 0x55 accepted only after the line returns high.
- Send 0x11 then 0x22 with `rx_ready`=0 → `rx_data`=0x11, `overrun`=1; after `err_clr`, `overrun`=0 and `rx_data` is still 0x11.
- Back-to-back 0x00, 0xFF, with `rx_ready` pulsed exactly at the second commit cycle → both delivered in order, `overrun`=0.
- Assert `rst` during bit 4 of 0x81, release, send 0x7E → all outputs 0 after reset, then `rx_data`=0x7E. With `UART_RX_PARITY_EN`, send 0x07 with a wrong even-parity bit → `parity_err`=1 and no `rx_valid`.
